// File: rtl/clk_time_pkg.sv
// Shared constants and state type for the seconds-of-day to HH:MM:SS BCD converter.
package clk_time_pkg;

    localparam int unsigned SEC_PER_DAY  = 86400;
    localparam int unsigned SEC_PER_HOUR = 3600;
    localparam int unsigned SEC_PER_MIN  = 60;
    localparam int unsigned HOUR_STEPS   = 5;
    localparam int unsigned MIN_STEPS    = 6;

    // 86399 fits in 17 bits, so this is the working width of the remainder
    localparam int unsigned REM_W = 17;

    typedef enum logic [1:0] {
        IDLE,
        HRS,
        MIN,
        CONV
    } hms_state_t;

endpackage

// File: rtl/bin6_to_bcd.sv
// Combinational 6-bit binary to two-digit packed BCD, used for hours, minutes and seconds.
module bin6_to_bcd (
    input  logic [5:0] value,
    output logic [7:0] bcd
);

    logic [3:0] tens;
    logic [5:0] base;

    always_comb begin
        tens = 4'd0;
        base = 6'd0;
        if (value >= 6'd60) begin
            tens = 4'd6;
            base = 6'd60;
        end else if (value >= 6'd50) begin
            tens = 4'd5;
            base = 6'd50;
        end else if (value >= 6'd40) begin
            tens = 4'd4;
            base = 6'd40;
        end else if (value >= 6'd30) begin
            tens = 4'd3;
            base = 6'd30;
        end else if (value >= 6'd20) begin
            tens = 4'd2;
            base = 6'd20;
        end else if (value >= 6'd10) begin
            tens = 4'd1;
            base = 6'd10;
        end
        bcd = {tens, 4'(value - base)};
    end

endmodule

// File: rtl/time_to_hms_bcd.sv
// Fixed-latency (12 edge) restoring-division converter from seconds-of-day to BCD hh/mm/ss.
// Optional macro TIME_TO_HMS_AUTO_CONVERT_EN: self-start whenever time_in changes.
module time_to_hms_bcd
    import clk_time_pkg::*;
#(
    parameter int TIME_W = 24
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [TIME_W-1:0] time_in,
    input  logic              start,
    output logic              ready,
    output logic              valid,
    output logic [7:0]        hh_bcd,
    output logic [7:0]        mm_bcd,
    output logic [7:0]        ss_bcd,
    output logic              err
);

    hms_state_t       state, state_nxt;
    logic [2:0]       step, step_nxt;
    logic [REM_W-1:0] rem, rem_nxt;
    logic [4:0]       hour, hour_nxt;
    logic [5:0]       minute, minute_nxt;
    logic             oor, oor_nxt;
    logic             valid_nxt, err_nxt;
    logic [7:0]       hh_nxt, mm_nxt, ss_nxt;
    logic [7:0]       hh_conv, mm_conv, ss_conv;
    logic [REM_W-1:0] hour_unit, min_unit;
    logic             accept;

    assign ready = (state == IDLE);

`ifdef TIME_TO_HMS_AUTO_CONVERT_EN
    logic [TIME_W-1:0] last_in;

    assign accept = start || (time_in != last_in);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_in <= '0;
        end else if (state == IDLE && accept) begin
            last_in <= time_in;
        end
    end
`else
    assign accept = start;
`endif

    bin6_to_bcd u_hh (.value({1'b0, hour}), .bcd(hh_conv));
    bin6_to_bcd u_mm (.value(minute),       .bcd(mm_conv));
    bin6_to_bcd u_ss (.value(rem[5:0]),     .bcd(ss_conv));

    // One quotient bit per cycle: subtract the shifted divisor when it fits
    always_comb begin
        hour_unit  = REM_W'(SEC_PER_HOUR) << step;
        min_unit   = REM_W'(SEC_PER_MIN) << step;
        state_nxt  = state;
        step_nxt   = step;
        rem_nxt    = rem;
        hour_nxt   = hour;
        minute_nxt = minute;
        oor_nxt    = oor;
        valid_nxt  = 1'b0;
        err_nxt    = err;
        hh_nxt     = hh_bcd;
        mm_nxt     = mm_bcd;
        ss_nxt     = ss_bcd;
        case (state)
            IDLE: begin
                if (accept) begin
                    rem_nxt    = time_in[REM_W-1:0];
                    oor_nxt    = (time_in >= TIME_W'(SEC_PER_DAY));
                    hour_nxt   = '0;
                    minute_nxt = '0;
                    step_nxt   = 3'(HOUR_STEPS - 1);
                    state_nxt  = HRS;
                end
            end
            HRS: begin
                if (rem >= hour_unit) begin
                    rem_nxt        = rem - hour_unit;
                    hour_nxt[step] = 1'b1;
                end
                if (step == 3'd0) begin
                    step_nxt  = 3'(MIN_STEPS - 1);
                    state_nxt = MIN;
                end else begin
                    step_nxt = step - 3'd1;
                end
            end
            MIN: begin
                if (rem >= min_unit) begin
                    rem_nxt          = rem - min_unit;
                    minute_nxt[step] = 1'b1;
                end
                if (step == 3'd0) begin
                    state_nxt = CONV;
                end else begin
                    step_nxt = step - 3'd1;
                end
            end
            CONV: begin
                // Out-of-range inputs leave garbage quotients, so blank the display instead
                hh_nxt    = oor ? 8'h00 : hh_conv;
                mm_nxt    = oor ? 8'h00 : mm_conv;
                ss_nxt    = oor ? 8'h00 : ss_conv;
                err_nxt   = oor;
                valid_nxt = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            step   <= '0;
            rem    <= '0;
            hour   <= '0;
            minute <= '0;
            oor    <= 1'b0;
            valid  <= 1'b0;
            err    <= 1'b0;
            hh_bcd <= 8'h00;
            mm_bcd <= 8'h00;
            ss_bcd <= 8'h00;
        end else begin
            state  <= state_nxt;
            step   <= step_nxt;
            rem    <= rem_nxt;
            hour   <= hour_nxt;
            minute <= minute_nxt;
            oor    <= oor_nxt;
            valid  <= valid_nxt;
            err    <= err_nxt;
            hh_bcd <= hh_nxt;
            mm_bcd <= mm_nxt;
            ss_bcd <= ss_nxt;
        end
    end

endmodule

// File: tb/tb_time_to_hms_bcd.sv
// Directed bench for time_to_hms_bcd: vector table plus reset-abort, back-to-back and auto-convert sequences.
module tb_time_to_hms_bcd;

    localparam int TIME_W = 24;

    logic              clk = 1'b0;
    logic              reset;
    logic [TIME_W-1:0] time_in;
    logic              start;
    logic              ready;
    logic              valid;
    logic [7:0]        hh_bcd, mm_bcd, ss_bcd;
    logic              err;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [TIME_W-1:0] t;
        logic [7:0]        hh;
        logic [7:0]        mm;
        logic [7:0]        ss;
        logic              err;
    } vec_t;

    vec_t vecs[9];

    always #5 clk = ~clk;

    time_to_hms_bcd #(.TIME_W(TIME_W)) dut (
        .clk     (clk),
        .reset   (reset),
        .time_in (time_in),
        .start   (start),
        .ready   (ready),
        .valid   (valid),
        .hh_bcd  (hh_bcd),
        .mm_bcd  (mm_bcd),
        .ss_bcd  (ss_bcd),
        .err     (err)
    );

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (!ready && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!ready) check_output("ready_timeout", 32'(ready), 32'd1);
    endtask

    // Starts one conversion and returns how many edges after the accept valid appeared
    task automatic apply_stimulus(input logic [TIME_W-1:0] t, output int lat);
        int n = 0;
        wait_ready();
        time_in = t;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start   = 1'b0;
        time_in = t ^ 24'h0ABCDE;
        check_output("busy_ready", 32'(ready), 32'd0);
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        lat = n;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!valid && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        int lat;
        int cnt;

        vecs[0] = '{24'd0,        8'h00, 8'h00, 8'h00, 1'b0};
        vecs[1] = '{24'd45296,    8'h12, 8'h34, 8'h56, 1'b0};
        vecs[2] = '{24'd86399,    8'h23, 8'h59, 8'h59, 1'b0};
        vecs[3] = '{24'd86400,    8'h00, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{24'd3661,     8'h01, 8'h01, 8'h01, 1'b0};
        vecs[5] = '{24'hFFFFFF,   8'h00, 8'h00, 8'h00, 1'b1};
        vecs[6] = '{24'd86340,    8'h23, 8'h59, 8'h00, 1'b0};
        vecs[7] = '{24'd131072,   8'h00, 8'h00, 8'h00, 1'b1};
        vecs[8] = '{24'd45296,    8'h12, 8'h34, 8'h56, 1'b0};

        reset   = 1'b1;
        start   = 1'b0;
        time_in = '0;
        repeat (3) @(negedge clk);
        check_output("rst_ready", 32'(ready), 32'd1);
        check_output("rst_valid", 32'(valid), 32'd0);
        check_output("rst_hh", 32'(hh_bcd), 32'h00);
        check_output("rst_err", 32'(err), 32'd0);
        reset = 1'b0;

`ifndef TIME_TO_HMS_AUTO_CONVERT_EN
        foreach (vecs[i]) begin
            apply_stimulus(vecs[i].t, lat);
            check_output($sformatf("lat_%0d", i), 32'(lat), 32'd12);
            check_output($sformatf("hh_%0d", i), 32'(hh_bcd), 32'(vecs[i].hh));
            check_output($sformatf("mm_%0d", i), 32'(mm_bcd), 32'(vecs[i].mm));
            check_output($sformatf("ss_%0d", i), 32'(ss_bcd), 32'(vecs[i].ss));
            check_output($sformatf("err_%0d", i), 32'(err), 32'(vecs[i].err));
            check_output($sformatf("ready_at_valid_%0d", i), 32'(ready), 32'd1);
        end

        // Outputs must hold once the pulse is over
        @(negedge clk);
        check_output("hold_valid", 32'(valid), 32'd0);
        check_output("hold_hh", 32'(hh_bcd), 32'h12);
        check_output("hold_ss", 32'(ss_bcd), 32'h56);

        // Reset in the middle of the minute steps aborts the conversion
        wait_ready();
        time_in = 24'd3661;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        #1;
        check_output("abort_hh", 32'(hh_bcd), 32'h00);
        check_output("abort_mm", 32'(mm_bcd), 32'h00);
        check_output("abort_ss", 32'(ss_bcd), 32'h00);
        check_output("abort_ready", 32'(ready), 32'd1);
        check_output("abort_err", 32'(err), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        cnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        check_output("abort_no_valid", 32'(cnt), 32'd0);

        // start held high: one result every 13 cycles, busy starts ignored
        wait_ready();
        time_in = 24'd3599;
        start   = 1'b1;
        @(posedge clk);
        @(negedge clk);
        time_in = 24'd3600;
        wait_valid(lat);
        check_output("b2b_lat", 32'(lat), 32'd12);
        check_output("b2b0_hh", 32'(hh_bcd), 32'h00);
        check_output("b2b0_mm", 32'(mm_bcd), 32'h59);
        check_output("b2b0_ss", 32'(ss_bcd), 32'h59);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) begin
                check_output("b2b_busy", 32'(ready), 32'd0);
                time_in = 24'd3601;
            end
        end while (!valid && cnt < 20);
        check_output("b2b_period1", 32'(cnt), 32'd13);
        check_output("b2b1_hh", 32'(hh_bcd), 32'h01);
        check_output("b2b1_mm", 32'(mm_bcd), 32'h00);
        check_output("b2b1_ss", 32'(ss_bcd), 32'h00);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!valid && cnt < 20);
        start = 1'b0;
        check_output("b2b_period2", 32'(cnt), 32'd13);
        check_output("b2b2_hh", 32'(hh_bcd), 32'h01);
        check_output("b2b2_mm", 32'(mm_bcd), 32'h00);
        check_output("b2b2_ss", 32'(ss_bcd), 32'h01);
`else
        // Input changes alone trigger conversions
        @(negedge clk);
        time_in = 24'd59;
        wait_valid(lat);
        check_output("auto0_seen", 32'(valid), 32'd1);
        check_output("auto0_mm", 32'(mm_bcd), 32'h00);
        check_output("auto0_ss", 32'(ss_bcd), 32'h59);
        check_output("auto0_hh", 32'(hh_bcd), 32'h00);
        @(negedge clk);
        time_in = 24'd60;
        wait_valid(lat);
        check_output("auto1_seen", 32'(valid), 32'd1);
        check_output("auto1_mm", 32'(mm_bcd), 32'h01);
        check_output("auto1_ss", 32'(ss_bcd), 32'h00);
        check_output("auto1_err", 32'(err), 32'd0);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) cnt++;
        end
        check_output("auto_steady", 32'(cnt), 32'd0);
        check_output("auto_ready", 32'(ready), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_to_hms_bcd.md
Name: time_to_hms_bcd

Overview:
- Downstream stage of the 24-hour clock core.
- Consumes the 24-bit seconds-of-day value the clock produces (0..86399).
- Converts it in multiple cycles to packed-BCD hours, minutes and seconds for the display and driver stage.
- Uses a start/ready/valid handshake with fixed latency, so the display path never sees partial results.

Parameters:
- TIME_W, 24, width of time_in; must be >= 17.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- time_in  input  TIME_W  seconds since midnight, from the clock core's time_out.
- start  input  1  request a conversion; accepted only when ready=1.
- ready  output  1  high in IDLE; block can accept start.
- valid  output  1  one-cycle pulse when hh/mm/ss/err are updated.
- hh_bcd  output  8  hours as BCD, [7:4] tens and [3:0] ones (00..23).
- mm_bcd  output  8  minutes as BCD (00..59).
- ss_bcd  output  8  seconds as BCD (00..59).
- err  output  1  last accepted time_in was >= 86400.

Behaviour:
- Reset (async, active-high):
  - State goes to IDLE.
  - ready=1, valid=0, hh_bcd=mm_bcd=ss_bcd=8'h00, err=0.
  - Internal remainder and quotient registers are cleared.
- States are IDLE, HRS, MIN, CONV.
- IDLE:
  - ready=1.
  - On an edge with start=1, capture time_in into remainder register rem (17 bits; upper bits are checked for range).
  - Set range flag oor = (time_in >= 86400).
  - Clear hour and minute quotients; go to HRS with step index 4.
- HRS (5 cycles, k = 4..0):
  - If rem >= 3600<<k, then rem -= 3600<<k and hour[k] = 1.
  - After k=0, go to MIN with k=5.
- MIN (6 cycles, k = 5..0):
  - If rem >= 60<<k, then rem -= 60<<k and min[k] = 1.
  - After k=0, go to CONV.
- CONV (1 cycle):
  - Convert hour (0..23), min (0..59) and rem (0..59) to BCD.
  - Register them to outputs; set err=oor and pulse valid=1; return to IDLE.
  - If oor=1, the outputs are all forced to 8'h00 instead.
- Latency:
  - valid rises exactly 12 clock edges after the accepting edge: 1 accept, 5 HRS, 6 MIN; CONV writes on edge 12.
  - Latency is constant for all inputs, including out-of-range inputs.
- Busy:
  - ready=0 in HRS, MIN and CONV.
  - start while busy is ignored, not queued.
  - time_in changes while busy do not affect the result in flight.
- Back-to-back:
  - ready returns to 1 in the cycle valid is high.
  - start in that cycle is accepted; sustained throughput is one result per 13 cycles.
- Outputs hold their last values between valid pulses.
- Reset during HRS, MIN or CONV aborts the conversion: no valid pulse, outputs cleared.
- Bits of time_in above bit 16 that are non-zero set oor.

Optional Feature:
- Macro: TIME_TO_HMS_AUTO_CONVERT_EN.
- Defined:
  - The block holds an internal register last_in (reset 0) and self-starts in IDLE whenever time_in != last_in.
  - last_in updates on accept.
  - The start port is still honoured: start OR change-detect.
  - After reset, the first conversion occurs only when time_in differs from 0, or on start.
- Undefined: conversions begin only on start, and no last_in register exists.

Decomposition:
- Package clk_time_pkg holds:
  - SEC_PER_DAY = 86400, SEC_PER_HOUR = 3600, SEC_PER_MIN = 60.
  - HOUR_STEPS = 5 and MIN_STEPS = 6.
  - State enum hms_state_t (IDLE, HRS, MIN, CONV).
- One sub-module, bin6_to_bcd: combinational, 6-bit value 0..59 to 8-bit BCD. It is instanced three times in CONV (hours fit in 6 bits).

Test Plan:
- Reset asserted mid-MIN (e.g. 8 cycles after start) -> outputs 8'h00, ready=1, err=0 immediately; no valid pulse follows.
- time_in=0, start -> valid exactly 12 edges after accept; hh=8'h00, mm=8'h00, ss=8'h00, err=0.
- time_in=45296, start -> hh=8'h12, mm=8'h34, ss=8'h56; time_in=86399 -> hh=8'h23, mm=8'h59, ss=8'h59.
- time_in=86400, then 24'hFFFFFF -> each yields valid after 12 edges with err=1 and all BCD outputs 8'h00.
- start=1 held continuously with time_in stepping 3599, 3600, 3601 -> results 00:59:59, 01:00:00, 01:00:01.
  - One result per 13 cycles; no start is accepted while ready=0.
- With TIME_TO_HMS_AUTO_CONVERT_EN defined, start=0, time_in 0 -> 59 -> 60 -> two valid pulses with 00:00:59 then 00:01:00; a steady input produces no further pulses.
